// File: rtl/pci_initiator.sv
// PCI-style bus initiator: runs 1-4 word read/write bursts from a small write buffer.
// Every bus-facing output is a register. A missing DEVSEL ends the transaction as a master abort.
module pci_initiator #(
  parameter logic [3:0] READ           = 4'b0110,
  parameter logic [3:0] WRITE          = 4'b0111,
  parameter int         DEVSEL_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        frame,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  output logic        IRDY,
  input  logic        TRDY,
  input  logic        DEVSEL,
  input  logic        req_start,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_len,
  input  logic [3:0]  req_be,
  input  logic        wr_load,
  input  logic [1:0]  wr_idx,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [1:0]  rd_idx,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int            CW       = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [CW-1:0] DEV_LAST = CW'(DEVSEL_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT_DEVSEL, DATA, TURN} state_t;

  typedef struct packed {
    state_t        state;
    logic          frame;
    logic          irdy;
    logic [3:0]    cbe;
    logic [31:0]   ad;
    logic          ad_oe;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic [1:0]    rd_idx;
    logic [1:0]    idx;
    logic [2:0]    rem;
    logic [CW-1:0] dev_cnt;
    logic [3:0]    be;
    logic          write;
  } regs_t;

  localparam regs_t RESET_REGS = '{state: IDLE, frame: 1'b1, irdy: 1'b1, default: '0};

  regs_t       r_q;
  regs_t       w_d;
  logic        w_xfer;
  logic [31:0] r_wbuf [4];

  // A data phase completes only when both sides are ready and the target has claimed the cycle.
  assign w_xfer = !r_q.irdy && !TRDY && !DEVSEL;

  always_comb begin
    // NOTE: every field starts from its held value so no path through the case leaves one unassigned (no latches).
    w_d          = r_q;
    w_d.done     = 1'b0;
    w_d.rd_valid = 1'b0;
    case (r_q.state)
      IDLE: begin
        if (req_start) begin
          w_d.state   = ADDR;
          w_d.busy    = 1'b1;
          w_d.err     = 1'b0;
          w_d.frame   = 1'b0;
          w_d.ad      = req_addr;
          w_d.ad_oe   = 1'b1;
          w_d.cbe     = req_write ? WRITE : READ;
          w_d.be      = req_be;
          w_d.write   = req_write;
          w_d.idx     = 2'd0;
          w_d.rem     = {1'b0, req_len} + 3'd1;
          w_d.dev_cnt = '0;
        end
      end
      ADDR: begin
        w_d.state = WAIT_DEVSEL;
        w_d.irdy  = 1'b0;
        w_d.cbe   = r_q.be;
        w_d.ad    = r_wbuf[0];
        w_d.ad_oe = r_q.write;
        w_d.frame = (r_q.rem == 3'd1);
      end
      WAIT_DEVSEL, DATA: begin
        if (w_xfer) begin
          if (!r_q.write) begin
            w_d.rd_valid = 1'b1;
            w_d.rd_data  = AD;
            w_d.rd_idx   = r_q.idx;
          end
          if (r_q.rem == 3'd1) begin
            w_d.state = TURN;
            w_d.frame = 1'b1;
            w_d.irdy  = 1'b1;
            w_d.ad_oe = 1'b0;
            w_d.cbe   = 4'b0000;
            w_d.done  = 1'b1;
          end else begin
            w_d.state = DATA;
            w_d.idx   = r_q.idx + 2'd1;
            w_d.rem   = r_q.rem - 3'd1;
            w_d.ad    = r_wbuf[r_q.idx + 2'd1];
            w_d.frame = (r_q.rem == 3'd2);
          end
        end else if (r_q.state == WAIT_DEVSEL) begin
          if (!DEVSEL) begin
            w_d.state = DATA;
          end else if (r_q.dev_cnt == DEV_LAST) begin
            w_d.state = TURN;
            w_d.frame = 1'b1;
            w_d.irdy  = 1'b1;
            w_d.ad_oe = 1'b0;
            w_d.cbe   = 4'b0000;
            w_d.err   = 1'b1;
            w_d.done  = 1'b1;
          end else begin
            w_d.dev_cnt = r_q.dev_cnt + CW'(1);
          end
        end
      end
      TURN: begin
        w_d.state = IDLE;
        w_d.busy  = 1'b0;
      end
      default: w_d.state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= RESET_REGS;
    else     r_q <= w_d;
  end

  // NOTE: the write buffer is plain storage with no reset; its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (wr_load && !r_q.busy) r_wbuf[wr_idx] <= wr_data;
  end

  assign AD       = r_q.ad_oe ? r_q.ad : 32'bz;
  assign frame    = r_q.frame;
  assign IRDY     = r_q.irdy;
  assign CBE      = r_q.cbe;
  assign busy     = r_q.busy;
  assign done     = r_q.done;
  assign err      = r_q.err;
  assign rd_valid = r_q.rd_valid;
  assign rd_data  = r_q.rd_data;
  assign rd_idx   = r_q.rd_idx;

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: the target side is driven from the bench and every
// bus phase is checked at the falling edge against hand-computed values.
module tb_pci_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame, IRDY, TRDY, DEVSEL;
  logic [3:0]  CBE;
  wire  [31:0] ad;
  logic        req_start, req_write, wr_load;
  logic [31:0] req_addr, wr_data, rd_data;
  logic [1:0]  req_len, wr_idx, rd_idx;
  logic [3:0]  req_be;
  logic        rd_valid, busy, done, err;

  logic        tb_oe;
  logic [31:0] tb_ad;
  assign ad = tb_oe ? tb_ad : 32'bz;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wb [4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};

  always #5 clk = ~clk;

  pci_initiator dut (
    .clk(clk), .rst(rst), .frame(frame), .CBE(CBE), .AD(ad), .IRDY(IRDY),
    .TRDY(TRDY), .DEVSEL(DEVSEL), .req_start(req_start), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_be(req_be), .wr_load(wr_load),
    .wr_idx(wr_idx), .wr_data(wr_data), .rd_data(rd_data), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drives a probe pattern onto AD; it reads back intact only if the DUT has released the bus.
  task automatic check_released(input string tag);
    logic        save_oe;
    logic [31:0] save_ad;
    save_oe = tb_oe;
    save_ad = tb_ad;
    tb_oe   = 1'b1;
    tb_ad   = 32'h5A5A_A5A5;
    #1;
    check({tag, "_ad_released"}, ad, 32'h5A5A_A5A5);
    tb_oe = save_oe;
    tb_ad = save_ad;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_frame"}, frame, 1'b1);
    check({tag, "_irdy"}, IRDY, 1'b1);
    check({tag, "_cbe"}, CBE, 4'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_rd_valid"}, rd_valid, 1'b0);
    check({tag, "_rd_data"}, rd_data, 32'h0);
    check({tag, "_rd_idx"}, rd_idx, 2'd0);
    check_released(tag);
  endtask

  task automatic start(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                       input logic [3:0] be);
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    req_be    = be;
    req_start = 1'b1;
    step();
    req_start = 1'b0;
  endtask

  task automatic single_write(input string tag);
    TRDY   = 1'b0;
    DEVSEL = 1'b0;
    start(1'b1, 32'h0000_0300, 2'd0, 4'h5);
    check({tag, "_addr_err_cleared"}, err, 1'b0);
    check({tag, "_addr_frame"}, frame, 1'b0);
    check({tag, "_addr_ad"}, ad, 32'h0000_0300);
    check({tag, "_addr_cbe"}, CBE, 4'b0111);
    step();
    check({tag, "_data_frame"}, frame, 1'b1);
    check({tag, "_data_irdy"}, IRDY, 1'b0);
    check({tag, "_data_ad"}, ad, wb[0]);
    check({tag, "_data_cbe"}, CBE, 4'h5);
    step();
    check({tag, "_turn_done"}, done, 1'b1);
    check({tag, "_turn_irdy"}, IRDY, 1'b1);
    check({tag, "_turn_frame"}, frame, 1'b1);
    step();
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; TRDY = 1'b1; DEVSEL = 1'b1; tb_oe = 1'b0; tb_ad = '0;
    req_start = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_be = '0;
    wr_load = 1'b0; wr_idx = '0; wr_data = '0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      wr_load = 1'b1;
      wr_idx  = 2'(i);
      wr_data = wb[i];
      step();
    end
    wr_load = 1'b0;

    // Four-word write with a zero-wait target; a stray request and buffer load mid-burst.
    TRDY   = 1'b0;
    DEVSEL = 1'b0;
    start(1'b1, 32'h0000_0100, 2'd3, 4'hF);
    check("w4_addr_frame", frame, 1'b0);
    check("w4_addr_ad", ad, 32'h0000_0100);
    check("w4_addr_cbe", CBE, 4'b0111);
    check("w4_addr_irdy", IRDY, 1'b1);
    check("w4_addr_busy", busy, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w4_d%0d_ad", i), ad, wb[i]);
      check($sformatf("w4_d%0d_cbe", i), CBE, 4'hF);
      check($sformatf("w4_d%0d_irdy", i), IRDY, 1'b0);
      check($sformatf("w4_d%0d_frame", i), frame, (i == 3) ? 1'b1 : 1'b0);
      check($sformatf("w4_d%0d_done", i), done, 1'b0);
      if (i == 1) begin
        req_start = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0BAD;
        wr_load = 1'b1; wr_idx = 2'd0; wr_data = 32'hBADB_AD00;
        step();
        req_start = 1'b0; wr_load = 1'b0;
      end else begin
        step();
      end
    end
    check("w4_turn_done", done, 1'b1);
    check("w4_turn_frame", frame, 1'b1);
    check("w4_turn_irdy", IRDY, 1'b1);
    check_released("w4_turn");
    step();
    check("w4_idle_done", done, 1'b0);
    check("w4_idle_busy", busy, 1'b0);

    // Two-word read with one target wait state before the second word.
    TRDY   = 1'b1;
    DEVSEL = 1'b1;
    start(1'b0, 32'h0000_0200, 2'd1, 4'h3);
    check("r2_addr_ad", ad, 32'h0000_0200);
    check("r2_addr_cbe", CBE, 4'b0110);
    check("r2_addr_frame", frame, 1'b0);
    step();
    check("r2_wait_irdy", IRDY, 1'b0);
    check("r2_wait_frame", frame, 1'b0);
    check("r2_wait_cbe", CBE, 4'h3);
    check("r2_wait_rd_valid", rd_valid, 1'b0);
    check_released("r2_wait");
    tb_oe = 1'b1; tb_ad = 32'hDEAD_BEEF; TRDY = 1'b0; DEVSEL = 1'b0;
    step();
    check("r2_w0_rd_valid", rd_valid, 1'b1);
    check("r2_w0_rd_data", rd_data, 32'hDEAD_BEEF);
    check("r2_w0_rd_idx", rd_idx, 2'd0);
    check("r2_w0_frame", frame, 1'b1);
    check("r2_w0_irdy", IRDY, 1'b0);
    TRDY = 1'b1; tb_ad = 32'h1234_5678;
    step();
    check("r2_ws_rd_valid", rd_valid, 1'b0);
    check("r2_ws_rd_data", rd_data, 32'hDEAD_BEEF);
    check("r2_ws_irdy", IRDY, 1'b0);
    check("r2_ws_cbe", CBE, 4'h3);
    check("r2_ws_done", done, 1'b0);
    TRDY = 1'b0;
    step();
    check("r2_w1_rd_valid", rd_valid, 1'b1);
    check("r2_w1_rd_data", rd_data, 32'h1234_5678);
    check("r2_w1_rd_idx", rd_idx, 2'd1);
    check("r2_w1_done", done, 1'b1);
    check("r2_w1_irdy", IRDY, 1'b1);
    tb_oe = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1;
    step();
    check("r2_idle_rd_valid", rd_valid, 1'b0);
    check("r2_idle_busy", busy, 1'b0);

    // Master abort: DEVSEL never asserts, abort lands on the fourth edge after the address phase.
    start(1'b0, 32'h0000_0400, 2'd1, 4'hF);
    step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ma_w%0d_irdy", k), IRDY, 1'b0);
      check($sformatf("ma_w%0d_err", k), err, 1'b0);
      check($sformatf("ma_w%0d_done", k), done, 1'b0);
      check($sformatf("ma_w%0d_rd_valid", k), rd_valid, 1'b0);
      step();
    end
    check("ma_frame", frame, 1'b1);
    check("ma_irdy", IRDY, 1'b1);
    check("ma_err", err, 1'b1);
    check("ma_done", done, 1'b1);
    check("ma_rd_valid", rd_valid, 1'b0);
    check_released("ma");
    step();
    check("ma_idle_err_held", err, 1'b1);
    check("ma_idle_done", done, 1'b0);
    check("ma_idle_busy", busy, 1'b0);
    check("ma_idle_rd_valid", rd_valid, 1'b0);

    // Single-word write: also confirms err clears on start and the buffer ignored the busy load.
    single_write("w1");

    // Reset in the data phase after the second of four words.
    TRDY   = 1'b0;
    DEVSEL = 1'b0;
    start(1'b1, 32'h0000_0500, 2'd3, 4'hF);
    step();
    step();
    step();
    check("rm_before_ad", ad, wb[2]);
    rst = 1'b1;
    #1;
    check_reset_state("rm_async");
    step();
    check("rm_hold_done", done, 1'b0);
    rst = 1'b0;
    step();
    check("rm_after_done", done, 1'b0);
    check("rm_after_busy", busy, 1'b0);
    single_write("rm_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
